// File: rtl/pep_ks_res_cmd_sched.sv
// pep_ks_res_cmd_sched: expands one batch command (wp, rp) into one result
// command per KS block column, bounded by an in-flight credit limit so the
// downstream formatter command FIFO can never overflow.
//
// Optional feature macro: PEP_KS_RES_CMD_SCHED_STATS_EN (statistics counters).
//
// Ports:
//   clk, s_rst                      clock, synchronous active-high reset
//   batch_wp/rp/vld, batch_rdy      batch command input (batch_rdy is combinational)
//   res_cmd_ks_loop/wp/rp/vld, rdy  result command output (registered)
//   res_done                        one credit returned by the formatter
//   reset_cache                     flush: back to IDLE, full credits
//   busy, err                       registered status / one-cycle error pulse
//   stat_batch_cnt, stat_stall_cnt  statistics (0 when the feature is off)
module pep_ks_res_cmd_sched #(
    parameter int unsigned KS_BLOCK_COL_NB = 8,
    parameter int unsigned LBX             = 2,
    parameter int unsigned PTR_W           = 5,
    parameter int unsigned BATCH_PBS_NB    = 8,
    parameter int unsigned MAX_INFLIGHT    = 4,
    parameter int unsigned KS_LOOP_W       = 10
) (
    input  logic                 clk,
    input  logic                 s_rst,
    input  logic [PTR_W-1:0]     batch_wp,
    input  logic [PTR_W-1:0]     batch_rp,
    input  logic                 batch_vld,
    output logic                 batch_rdy,
    output logic [KS_LOOP_W-1:0] res_cmd_ks_loop,
    output logic [PTR_W-1:0]     res_cmd_wp,
    output logic [PTR_W-1:0]     res_cmd_rp,
    output logic                 res_cmd_vld,
    input  logic                 res_cmd_rdy,
    input  logic                 res_done,
    input  logic                 reset_cache,
    output logic                 busy,
    output logic                 err,
    output logic [31:0]          stat_batch_cnt,
    output logic [31:0]          stat_stall_cnt
);

    localparam int unsigned COL_W  = (KS_BLOCK_COL_NB > 1) ? $clog2(KS_BLOCK_COL_NB) : 1;
    localparam int unsigned CRED_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(KS_BLOCK_COL_NB - 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_INFLIGHT);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                 state, state_nxt;
    logic [COL_W-1:0]       col, col_nxt;
    logic [CRED_W-1:0]      credits, credits_nxt;
    logic [PTR_W-1:0]       wp_nxt, rp_nxt;
    logic [KS_LOOP_W-1:0]   ks_loop_nxt;
    logic                   vld_nxt, err_nxt, busy_nxt;
    logic [PTR_W-1:0]       elt_nb;
    logic                   elt_legal, accept, fire, final_fire, held, done_ok;

    // Handshake decode and element-count legality
    always_comb begin
        elt_nb     = batch_wp - batch_rp;   // modulo 2^PTR_W by construction
        elt_legal  = (elt_nb != '0) && (32'(elt_nb) <= BATCH_PBS_NB);
        batch_rdy  = (state == IDLE) && !reset_cache && !s_rst;
        accept     = batch_vld && batch_rdy;
        fire       = res_cmd_vld && res_cmd_rdy;
        final_fire = fire && (col == COL_LAST);
        held       = res_cmd_vld && !res_cmd_rdy;
        // A return at full credits is only legal if a fire consumes one the same cycle
        done_ok    = res_done && ((credits != CRED_MAX) || fire);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        credits_nxt = credits;
        wp_nxt      = res_cmd_wp;
        rp_nxt      = res_cmd_rp;
        vld_nxt     = res_cmd_vld;
        err_nxt     = res_done && !done_ok;

        if (fire && !done_ok) begin
            credits_nxt = credits - CRED_W'(1);
        end else if (done_ok && !fire) begin
            credits_nxt = credits + CRED_W'(1);
        end

        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (accept) begin
                    if (elt_legal) begin
                        state_nxt = ISSUE;
                        col_nxt   = '0;
                        wp_nxt    = batch_wp;
                        rp_nxt    = batch_rp;
                        vld_nxt   = (credits_nxt != '0);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (final_fire) begin
                    state_nxt = IDLE;
                    col_nxt   = '0;
                    vld_nxt   = 1'b0;
                end else if (held) begin
                    vld_nxt = 1'b1;
                end else begin
                    if (fire) begin
                        col_nxt = col + COL_W'(1);
                    end
                    vld_nxt = (credits_nxt != '0);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush overrides everything except s_rst; a held command is dropped
        if (reset_cache) begin
            state_nxt   = IDLE;
            col_nxt     = '0;
            credits_nxt = CRED_MAX;
            vld_nxt     = 1'b0;
            err_nxt     = 1'b0;
        end

        ks_loop_nxt = KS_LOOP_W'(32'(col_nxt) * LBX);
        busy_nxt    = (state_nxt != IDLE) || (credits_nxt != CRED_MAX);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state           <= IDLE;
            col             <= '0;
            credits         <= CRED_MAX;
            res_cmd_vld     <= 1'b0;
            res_cmd_ks_loop <= '0;
            res_cmd_wp      <= '0;
            res_cmd_rp      <= '0;
            err             <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            col             <= col_nxt;
            credits         <= credits_nxt;
            res_cmd_vld     <= vld_nxt;
            res_cmd_ks_loop <= ks_loop_nxt;
            res_cmd_wp      <= wp_nxt;
            res_cmd_rp      <= rp_nxt;
            err             <= err_nxt;
            busy            <= busy_nxt;
        end
    end

`ifdef PEP_KS_RES_CMD_SCHED_STATS_EN
    logic stall_cycle;
    logic batch_done;

    always_comb begin
        stall_cycle = (state == ISSUE) && ((credits == '0) || held);
        batch_done  = final_fire && !reset_cache;
    end

    // Saturating statistics; only s_rst clears them
    always_ff @(posedge clk) begin
        if (s_rst) begin
            stat_batch_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (batch_done && (stat_batch_cnt != '1)) begin
                stat_batch_cnt <= stat_batch_cnt + 32'(1);
            end
            if (stall_cycle && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'(1);
            end
        end
    end
`else
    assign stat_batch_cnt = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pep_ks_res_cmd_sched.sv
// Directed self-checking bench for pep_ks_res_cmd_sched (default parameters).
module tb_pep_ks_res_cmd_sched;

    localparam int unsigned PTR_W     = 5;
    localparam int unsigned KS_LOOP_W = 10;
    localparam int unsigned LBX       = 2;
    localparam int unsigned COL_NB    = 8;

    logic                 clk = 1'b0;
    logic                 s_rst;
    logic [PTR_W-1:0]     batch_wp, batch_rp;
    logic                 batch_vld, batch_rdy;
    logic [KS_LOOP_W-1:0] res_cmd_ks_loop;
    logic [PTR_W-1:0]     res_cmd_wp, res_cmd_rp;
    logic                 res_cmd_vld, res_cmd_rdy, res_done, reset_cache;
    logic                 busy, err;
    logic [31:0]          stat_batch_cnt, stat_stall_cnt;

    int checks = 0;
    int errors = 0;

    pep_ks_res_cmd_sched #(
        .KS_BLOCK_COL_NB(8), .LBX(2), .PTR_W(5), .BATCH_PBS_NB(8),
        .MAX_INFLIGHT(4), .KS_LOOP_W(10)
    ) dut (
        .clk(clk), .s_rst(s_rst),
        .batch_wp(batch_wp), .batch_rp(batch_rp), .batch_vld(batch_vld), .batch_rdy(batch_rdy),
        .res_cmd_ks_loop(res_cmd_ks_loop), .res_cmd_wp(res_cmd_wp), .res_cmd_rp(res_cmd_rp),
        .res_cmd_vld(res_cmd_vld), .res_cmd_rdy(res_cmd_rdy), .res_done(res_done),
        .reset_cache(reset_cache), .busy(busy), .err(err),
        .stat_batch_cnt(stat_batch_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one batch to completion with res_done echoed two cycles after each fire
    task automatic run_full_batch(input logic [PTR_W-1:0] wp, input logic [PTR_W-1:0] rp,
                                  output int nfire);
        logic d0, d1;
        res_cmd_rdy = 1'b1;
        batch_wp = wp; batch_rp = rp; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        nfire = 0; d0 = 1'b0; d1 = 1'b0;
        for (int cyc = 0; cyc < 40 && (nfire < int'(COL_NB) || d0 || d1); cyc++) begin
            res_done = d1; d1 = d0; d0 = res_cmd_vld;
            if (res_cmd_vld) nfire++;
            step();
        end
        res_done = 1'b0;
    endtask

    task automatic flush();
        reset_cache = 1'b1;
        step();
        reset_cache = 1'b0;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; batch_wp = '0; batch_rp = '0; batch_vld = 1'b0;
        res_cmd_rdy = 1'b0; res_done = 1'b0; reset_cache = 1'b0;
        step(); step();
        checks++;
        if (res_cmd_vld !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: vld=%b err=%b busy=%b expected 0 0 0", res_cmd_vld, err, busy);
        end
        checks++;
        if (res_cmd_ks_loop !== '0 || res_cmd_wp !== '0 || res_cmd_rp !== '0) begin
            errors++; $display("FAIL reset_data: ks=%0d wp=%0d rp=%0d expected 0 0 0", res_cmd_ks_loop, res_cmd_wp, res_cmd_rp);
        end
        checks++;
        if (batch_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: batch_rdy=%b expected 0", batch_rdy);
        end
        s_rst = 1'b0;
        #1;
        checks++;
        if (batch_rdy !== 1'b1) begin
            errors++; $display("FAIL idle_rdy: batch_rdy=%b expected 1", batch_rdy);
        end
    endtask

    task automatic test_single_batch();
        int nfire, cyc;
        logic d0, d1;
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        batch_wp = 5'd5; batch_rp = 5'd2; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        checks++;
        if (res_cmd_vld !== 1'b1) begin
            errors++; $display("FAIL sb_first_latency: vld=%b expected 1", res_cmd_vld);
        end
        nfire = 0; cyc = 0; d0 = 1'b0; d1 = 1'b0;
        while ((nfire < int'(COL_NB) || d0 || d1) && cyc < 40) begin
            res_done = d1; d1 = d0; d0 = 1'b0;
            if (res_cmd_vld) begin
                checks++;
                if (res_cmd_ks_loop !== KS_LOOP_W'(nfire * LBX) || res_cmd_wp !== 5'd5 || res_cmd_rp !== 5'd2) begin
                    errors++;
                    $display("FAIL sb_cmd%0d: ks=%0d wp=%0d rp=%0d expected %0d 5 2",
                             nfire, res_cmd_ks_loop, res_cmd_wp, res_cmd_rp, nfire * LBX);
                end
                nfire++; d0 = 1'b1;
            end
            if (cyc == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL sb_busy_mid: busy=%b expected 1", busy);
                end
            end
            step(); cyc++;
        end
        res_done = 1'b0;
        checks++;
        if (nfire != int'(COL_NB) || cyc >= 40) begin
            errors++; $display("FAIL sb_fire_count: fires=%0d cycles=%0d expected 8 fires within 40", nfire, cyc);
        end
        checks++;
        if (busy !== 1'b0 || res_cmd_vld !== 1'b0) begin
            errors++; $display("FAIL sb_end: busy=%b vld=%b expected 0 0", busy, res_cmd_vld);
        end
    endtask

    task automatic test_no_done();
        int nfire;
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        batch_wp = 5'd10; batch_rp = 5'd6; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        nfire = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_cmd_vld) begin
                checks++;
                if (res_cmd_ks_loop !== KS_LOOP_W'(nfire * LBX)) begin
                    errors++; $display("FAIL nd_ks%0d: ks=%0d expected %0d", nfire, res_cmd_ks_loop, nfire * LBX);
                end
                nfire++;
            end
            step();
        end
        checks++;
        if (nfire != 4 || res_cmd_vld !== 1'b0) begin
            errors++; $display("FAIL nd_credit_limit: fires=%0d vld=%b expected 4 0", nfire, res_cmd_vld);
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd8) begin
            errors++; $display("FAIL nd_resume: vld=%b ks=%0d expected 1 8", res_cmd_vld, res_cmd_ks_loop);
        end
        nfire = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_cmd_vld) nfire++;
            step();
        end
        checks++;
        if (nfire != 1) begin
            errors++; $display("FAIL nd_one_more: fires=%0d expected 1", nfire);
        end
        flush();
        checks++;
        if (res_cmd_vld !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nd_flush: vld=%b busy=%b expected 0 0", res_cmd_vld, busy);
        end
    endtask

    task automatic test_backpressure();
        int n6;
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        batch_wp = 5'd3; batch_rp = 5'd0; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        step(); step(); step();
        res_cmd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd6 || res_cmd_wp !== 5'd3 || res_cmd_rp !== 5'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b ks=%0d wp=%0d rp=%0d expected 1 6 3 0",
                         i, res_cmd_vld, res_cmd_ks_loop, res_cmd_wp, res_cmd_rp);
            end
            step();
        end
        res_cmd_rdy = 1'b1;
        n6 = 0;
        for (int i = 0; i < 4; i++) begin
            if (res_cmd_vld && res_cmd_ks_loop == 10'd6) n6++;
            step();
        end
        checks++;
        if (n6 != 1) begin
            errors++; $display("FAIL bp_no_dup: col3 fires=%0d expected 1", n6);
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd8) begin
            errors++; $display("FAIL bp_next_col: vld=%b ks=%0d expected 1 8", res_cmd_vld, res_cmd_ks_loop);
        end
        flush();
    endtask

    task automatic test_illegal();
        logic [PTR_W-1:0] iwp [2];
        logic [PTR_W-1:0] irp [2];
        iwp[0] = 5'd7; irp[0] = 5'd7;
        iwp[1] = 5'd9; irp[1] = 5'd0;
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            batch_wp = iwp[k]; batch_rp = irp[k]; batch_vld = 1'b1;
            #1;
            checks++;
            if (batch_rdy !== 1'b1) begin
                errors++; $display("FAIL ill%0d_rdy: batch_rdy=%b expected 1", k, batch_rdy);
            end
            step();
            batch_vld = 1'b0;
            checks++;
            if (err !== 1'b1 || res_cmd_vld !== 1'b0) begin
                errors++; $display("FAIL ill%0d_err: err=%b vld=%b expected 1 0", k, err, res_cmd_vld);
            end
            step();
            checks++;
            if (err !== 1'b0 || res_cmd_vld !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL ill%0d_after: err=%b vld=%b busy=%b expected 0 0 0", k, err, res_cmd_vld, busy);
            end
        end
    endtask

    task automatic test_boundary_elt();
        int nfire;
        run_full_batch(5'd8, 5'd0, nfire);
        checks++;
        if (nfire != int'(COL_NB) || err !== 1'b0) begin
            errors++; $display("FAIL elt8: fires=%0d err=%b expected 8 0", nfire, err);
        end
        run_full_batch(5'd1, 5'd30, nfire);
        checks++;
        if (nfire != int'(COL_NB) || busy !== 1'b0) begin
            errors++; $display("FAIL elt_wrap: fires=%0d busy=%b expected 8 0", nfire, busy);
        end
    endtask

    task automatic test_reset_cache();
        logic d0, d1;
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        batch_wp = 5'd6; batch_rp = 5'd0; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        d0 = 1'b0; d1 = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            res_done = d1; d1 = d0; d0 = res_cmd_vld;
            step();
        end
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd10) begin
            errors++; $display("FAIL rc_col5: vld=%b ks=%0d expected 1 10", res_cmd_vld, res_cmd_ks_loop);
        end
        res_done = 1'b0; res_cmd_rdy = 1'b0; reset_cache = 1'b1;
        #1;
        checks++;
        if (batch_rdy !== 1'b0) begin
            errors++; $display("FAIL rc_rdy: batch_rdy=%b expected 0", batch_rdy);
        end
        step();
        reset_cache = 1'b0;
        #1;
        checks++;
        if (res_cmd_vld !== 1'b0 || busy !== 1'b0 || batch_rdy !== 1'b1) begin
            errors++; $display("FAIL rc_flushed: vld=%b busy=%b rdy=%b expected 0 0 1", res_cmd_vld, busy, batch_rdy);
        end
        res_cmd_rdy = 1'b1;
        batch_wp = 5'd2; batch_rp = 5'd0; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd0 || res_cmd_wp !== 5'd2) begin
            errors++; $display("FAIL rc_restart: vld=%b ks=%0d wp=%0d expected 1 0 2", res_cmd_vld, res_cmd_ks_loop, res_cmd_wp);
        end
        flush();
    endtask

    task automatic test_simultaneous();
        res_cmd_rdy = 1'b1; res_done = 1'b0;
        batch_wp = 5'd4; batch_rp = 5'd0; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        step(); step(); step();
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd6) begin
            errors++; $display("FAIL sim_col3: vld=%b ks=%0d expected 1 6", res_cmd_vld, res_cmd_ks_loop);
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        checks++;
        if (res_cmd_vld !== 1'b1 || res_cmd_ks_loop !== 10'd8 || err !== 1'b0) begin
            errors++; $display("FAIL sim_fire_done: vld=%b ks=%0d err=%b expected 1 8 0", res_cmd_vld, res_cmd_ks_loop, err);
        end
        step();
        checks++;
        if (res_cmd_vld !== 1'b0) begin
            errors++; $display("FAIL sim_credit_one: vld=%b expected 0", res_cmd_vld);
        end
        flush();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL sim_spurious: err=%b busy=%b expected 1 0", err, busy);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL sim_err_pulse: err=%b expected 0", err);
        end
    endtask

    task automatic test_stats();
`ifdef PEP_KS_RES_CMD_SCHED_STATS_EN
        int nfire;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        run_full_batch(5'd5, 5'd2, nfire);
        run_full_batch(5'd8, 5'd0, nfire);
        run_full_batch(5'd1, 5'd30, nfire);
        checks++;
        if (stat_batch_cnt !== 32'd3 || stat_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_batches: batch=%0d stall=%0d expected 3 0", stat_batch_cnt, stat_stall_cnt);
        end
        res_cmd_rdy = 1'b0;
        batch_wp = 5'd2; batch_rp = 5'd0; batch_vld = 1'b1;
        step();
        batch_vld = 1'b0;
        step(); step(); step();
        checks++;
        if (stat_stall_cnt !== 32'd3) begin
            errors++; $display("FAIL stats_stall: stall=%0d expected 3", stat_stall_cnt);
        end
        flush();
        checks++;
        if (stat_batch_cnt !== 32'd3) begin
            errors++; $display("FAIL stats_keep: batch=%0d expected 3", stat_batch_cnt);
        end
        res_cmd_rdy = 1'b1;
`else
        checks++;
        if (stat_batch_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_off: batch=%0d stall=%0d expected 0 0", stat_batch_cnt, stat_stall_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_batch();
        test_no_done();
        test_backpressure();
        test_illegal();
        test_boundary_elt();
        test_reset_cache();
        test_simultaneous();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
